// File: rtl/mio_pkg.sv
// mio_pkg: shared encodings and widths for the MIO arbiter
package mio_pkg;
  localparam int MIO_W = 32;
  localparam int WAIT_W = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker, favours the master that did not win last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master round-robin arbiter holding the MIO bus for WAIT_CYCLES per access
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [MIO_W-1:0] m0_addr,
  input  logic [MIO_W-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_ack,
  output logic [MIO_W-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [MIO_W-1:0] m1_addr,
  input  logic [MIO_W-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_ack,
  output logic [MIO_W-1:0] m1_rdata,
  output logic [MIO_W-1:0] bus_addr,
  output logic             bus_mem_w,
  output logic [MIO_W-1:0] bus_wdata,
  input  logic [MIO_W-1:0] bus_rdata,
  output logic             busy
);
  state_t            state_q, state_d;
  logic              prio_q, prio_d, win_q, win_d, we_q, we_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [MIO_W-1:0]  addr_q, addr_d, wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [1:0]        gnt;
  rr_arb2 u_rr (
    .req ({m1_req, m0_req}),
    .last(~prio_q),
    .gnt (gnt)
  );
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = ACCESS;
        win_d   = gnt[1];
        we_d    = gnt[1] ? m1_we : m0_we;
        addr_d  = gnt[1] ? m1_addr : m0_addr;
        wdata_d = gnt[1] ? m1_wdata : m0_wdata;
        cnt_d   = WAIT_W'(WAIT_CYCLES - 1);
      end
      ACCESS: if (cnt_q == '0) begin
        state_d = DONE;
        rd0_d   = (!we_q && !win_q) ? bus_rdata : rd0_q;
        rd1_d   = (!we_q && win_q) ? bus_rdata : rd1_q;
      end else begin
        cnt_d = cnt_q - WAIT_W'(1);
      end
      DONE: begin
        state_d = IDLE;
        prio_d  = ~win_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign m0_gnt    = busy && !win_q;
  assign m1_gnt    = busy && win_q;
  assign m0_ack    = (state_q == DONE) && !win_q;
  assign m1_ack    = (state_q == DONE) && win_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_mem_w = (state_q == ACCESS) && we_q;
endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter: randomized and directed self-check of mio_arbiter against a transaction-level model
module tb_mio_arbiter;
  localparam int W = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_mem_w, busy;
  int          npass = 0;
  int          ntot = 0;
  int          cyc = 0;
  int          g_cyc = 0;
  int          prev_g;
  bit          fav;
  logic [31:0] mrd [2];
  mio_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_mem_w(bus_mem_w), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt"}, {m1_gnt, m0_gnt}, 0);
    chk({tag, "_ack"}, {m1_ack, m0_ack}, 0);
    chk({tag, "_mem_w"}, bus_mem_w, 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_rd0"}, m0_rdata, 0);
    chk({tag, "_rd1"}, m1_rdata, 0);
  endtask
  task automatic txn(input bit r0, input bit r1, input bit we0, input bit we1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] rd, input bit drop0);
    bit w, we, in;
    logic [31:0] a, d;
    w  = (r0 && r1) ? fav : r1;
    we = w ? we1 : we0;
    a  = w ? a1 : a0;
    d  = w ? d1 : d0;
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    bus_rdata = rd;
    for (int i = 1; i <= W + 2; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        g_cyc = cyc;
        if (drop0) begin
          m0_req = 0; m0_we = ~we0; m0_addr = ~a0; m0_wdata = ~d0;
        end
      end
      if (i == W + 2) begin
        m0_req = 0;
        m1_req = 0;
      end
      @(negedge clk);
      in = i <= W + 1;
      chk("busy", busy, in);
      chk("gnt0", m0_gnt, in && !w);
      chk("gnt1", m1_gnt, in && w);
      chk("ack0", m0_ack, i == W + 1 && !w);
      chk("ack1", m1_ack, i == W + 1 && w);
      chk("mem_w", bus_mem_w, we && i <= W);
      if (in) begin
        chk("bus_addr", bus_addr, a);
        chk("bus_wdata", bus_wdata, d);
      end
      if (i == W + 1 && !we) mrd[w] = rd;
      chk("rdata0", m0_rdata, mrd[0]);
      chk("rdata1", m1_rdata, mrd[1]);
    end
    fav = ~w;
  endtask
  task automatic pulse_reset();
    #2 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    fav = 0;
    mrd[0] = 0;
    mrd[1] = 0;
  endtask
  initial begin
    rst = 1;
    {m0_req, m0_we, m1_req, m1_we} = '0;
    m0_addr = 0; m0_wdata = 0; m1_addr = 0; m1_wdata = 0; bus_rdata = 0;
    fav = 0;
    mrd[0] = 0;
    mrd[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk);
    #1 rst = 0;
    txn(1, 0, 0, 0, 32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, 0);
    txn(0, 1, 0, 1, 0, 32'hF000_0000, 0, 32'h0000_00A5, 32'h1234_5678, 0);
    txn(1, 0, 0, 0, 32'h0000_0020, 0, 0, 0, 32'h0BAD_F00D, 1);
    pulse_reset();
    prev_g = -1;
    for (int k = 0; k < 4; k++) begin
      txn(1, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
          $urandom, $urandom, $urandom, 0);
      if (prev_g >= 0) chk("spacing", g_cyc - prev_g, W + 2);
      prev_g = g_cyc;
    end
    for (int k = 0; k < 24; k++) begin
      int rq;
      rq = $urandom_range(1, 3);
      txn(rq[0], rq[1], $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom_range(0, 3) == 0);
    end
    pulse_reset();
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 32'hF000_0000; m1_wdata = 32'h0000_00A5;
    @(posedge clk);
    @(negedge clk);
    chk("rw_mem_w_before", bus_mem_w, 1);
    chk("rw_gnt1_before", m1_gnt, 1);
    #2 rst = 1;
    #1;
    chk_idle_zero("rst_mid");
    @(posedge clk);
    #1;
    chk("rst_hold_ack", m1_ack, 0);
    rst = 0;
    fav = 0;
    txn(1, 1, 0, 0, 32'h0000_0030, 32'h0000_0040, 0, 0, 32'hCAFE_0001, 0);
    txn(1, 1, 0, 0, 32'h0000_0050, 32'h0000_0060, 0, 0, 32'hCAFE_0002, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
